// File: rtl/dmem_arbiter_pkg.sv
// Shared types and default sizing for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    LOCKED = 2'd1
  } arb_state_t;

  localparam int DEF_NREQ      = 2;
  localparam int DEF_MAX_BURST = 4;

endpackage

// File: rtl/dmem_arbiter_rr_pick.sv
// Rotating-priority encoder: first asserted request at or after ptr, wrapping modulo N.
module rr_pick #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          valid,
  output logic [IW-1:0] idx,
  output logic [N-1:0]  onehot
);

  always_comb begin
    int j;
    j      = 0;
    valid  = 1'b0;
    idx    = '0;
    onehot = '0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!valid && req[j]) begin
        valid     = 1'b1;
        idx       = IW'(j);
        onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous-read data memory between NREQ requesters,
// with optional bounded burst locking by the current owner.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter  int WIDTH     = 16,
  parameter  int D_ADDR_W  = 8,
  parameter  int NREQ      = DEF_NREQ,
  parameter  int MAX_BURST = DEF_MAX_BURST,
  localparam int PW        = $clog2(NREQ),
  localparam int CW        = $clog2(MAX_BURST + 1)
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          lock,
  input  logic [NREQ-1:0]          wr,
  input  logic [NREQ*D_ADDR_W-1:0] addr,
  input  logic [NREQ*WIDTH-1:0]    wdata,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          rvalid,
  output logic [WIDTH-1:0]         rdata,
  output logic [D_ADDR_W-1:0]      mem_addr,
  output logic                     mem_wr,
  output logic [WIDTH-1:0]         mem_wdata,
  input  logic [WIDTH-1:0]         mem_rdata,
  output logic [1:0]               state_o,
  output logic [PW-1:0]            owner_o
);

  arb_state_t      state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [PW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [NREQ-1:0] rvalid_q;
  logic [NREQ-1:0] gnt_c;
  logic [PW-1:0]   arb_ptr;
  logic            do_arb;
  logic            pick_valid;
  logic [PW-1:0]   pick_idx;
  logic [NREQ-1:0] pick_oh;

  function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] i);
    return (i == PW'(NREQ - 1)) ? '0 : i + 1'b1;
  endfunction

  rr_pick #(.N(NREQ)) u_pick (
    .req    (req),
    .ptr    (arb_ptr),
    .valid  (pick_valid),
    .idx    (pick_idx),
    .onehot (pick_oh)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    gnt_c   = '0;
    arb_ptr = ptr_q;
    do_arb  = 1'b0;
    case (state_q)
      ARB: do_arb = 1'b1;
      LOCKED: begin
        if (req[owner_q] && lock[owner_q]) begin
          gnt_c[owner_q] = 1'b1;
          cnt_d          = CW'(cnt_q + 1'b1);
          if (cnt_d == CW'(MAX_BURST)) begin
            state_d = ARB;
            ptr_d   = wrap_inc(owner_q);
          end
        end else begin
          // Lock released: arbitrate in this same cycle from the slot after the owner.
          state_d = ARB;
          arb_ptr = wrap_inc(owner_q);
          ptr_d   = arb_ptr;
          do_arb  = 1'b1;
        end
      end
      default: begin
        state_d = ARB;
        cnt_d   = '0;
      end
    endcase
    if (do_arb && pick_valid) begin
      gnt_c   = pick_oh;
      owner_d = pick_idx;
      if (lock[pick_idx] && (MAX_BURST > 1)) begin
        state_d = LOCKED;
        cnt_d   = CW'(1);
      end else begin
        state_d = ARB;
        ptr_d   = wrap_inc(pick_idx);
      end
    end
  end

  assign gnt = Reset ? gnt_c : '0;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wr    = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        mem_addr  = addr[i*D_ADDR_W +: D_ADDR_W];
        mem_wdata = wdata[i*WIDTH +: WIDTH];
        mem_wr    = wr[i];
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q  <= ARB;
      ptr_q    <= '0;
      owner_q  <= '0;
      cnt_q    <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      cnt_q    <= cnt_d;
      rvalid_q <= gnt & ~wr;
    end
  end

  assign rvalid  = rvalid_q;
  assign rdata   = mem_rdata;
  assign state_o = state_q;
  assign owner_o = owner_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: grant checks inline, read completions through a scoreboard.
module tb_dmem_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [1:0]  req, lock, wr;
  logic [15:0] addr;
  logic [31:0] wdata;
  logic [1:0]  gnt, rvalid;
  logic [15:0] rdata;
  logic [7:0]  mem_addr;
  logic        mem_wr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic [1:0]  state_o;
  logic [0:0]  owner_o;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  typedef struct {
    int          port;
    logic [15:0] data;
    int          due;
  } exp_t;
  exp_t sb[$];

  logic [15:0] mem [256];

  dmem_arbiter dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .req       (req),
    .lock      (lock),
    .wr        (wr),
    .addr      (addr),
    .wdata     (wdata),
    .gnt       (gnt),
    .rvalid    (rvalid),
    .rdata     (rdata),
    .mem_addr  (mem_addr),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .state_o   (state_o),
    .owner_o   (owner_o)
  );

  always #5 Clk = ~Clk;

  always @(posedge Clk) cyc <= cyc + 1;

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = {8'hA5, 8'(i)};
    mem[8'h2A] = 16'hBEEF;
  end

  always @(posedge Clk) begin
    if (mem_wr) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem[mem_addr];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step(input logic [1:0] rq, input logic [1:0] lk, input logic [1:0] w,
                      input logic [7:0] a0, input logic [7:0] a1,
                      input logic [15:0] d0, input logic [15:0] d1,
                      input logic [1:0] eg, input logic [15:0] erd, input string nm);
    @(negedge Clk);
    req = rq; lock = lk; wr = w; addr = {a1, a0}; wdata = {d1, d0};
    #1;
    chk({nm, "_gnt"}, 32'(gnt), 32'(eg));
    if (eg != 2'b00) begin
      int p;
      p = eg[1] ? 1 : 0;
      chk({nm, "_addr"}, 32'(mem_addr), 32'(p == 1 ? a1 : a0));
      chk({nm, "_wr"}, 32'(mem_wr), 32'(w[p]));
      if (w[p]) chk({nm, "_wdata"}, 32'(mem_wdata), 32'(p == 1 ? d1 : d0));
      else sb.push_back('{p, erd, cyc + 1});
    end else begin
      chk({nm, "_idle_wr"}, 32'(mem_wr), 32'd0);
    end
  endtask

  // Scoreboard monitor: every read grant must complete exactly one cycle later.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      if (sb.size() > 0 && sb[0].due == cyc) begin
        e = sb.pop_front();
        chk("rvalid", 32'(rvalid), 32'(2'b01 << e.port));
        chk("rdata", 32'(rdata), 32'(e.data));
      end else if (rvalid != 2'b00) begin
        checks++;
        failures++;
        $display("FAIL rvalid_unexpected: got %0h expected 0", rvalid);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b0; req = '0; lock = '0; wr = '0; addr = '0; wdata = '0;
    repeat (3) @(negedge Clk);
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    Reset = 1'b1;

    step(2'b01, 2'b00, 2'b01, 8'h05, 8'h00, 16'h1234, 16'h0000, 2'b01, 16'h0000, "write");
    step(2'b01, 2'b00, 2'b00, 8'h05, 8'h00, 16'h0000, 16'h0000, 2'b01, 16'h1234, "readback");
    step(2'b10, 2'b00, 2'b00, 8'h00, 8'h2A, 16'h0000, 16'h0000, 2'b10, 16'hBEEF, "read2a");

    step(2'b11, 2'b00, 2'b00, 8'h10, 8'h11, 16'h0, 16'h0, 2'b01, 16'hA510, "rot0");
    step(2'b11, 2'b00, 2'b00, 8'h10, 8'h11, 16'h0, 16'h0, 2'b10, 16'hA511, "rot1");
    step(2'b11, 2'b00, 2'b00, 8'h10, 8'h11, 16'h0, 16'h0, 2'b01, 16'hA510, "rot2");
    step(2'b11, 2'b00, 2'b00, 8'h10, 8'h11, 16'h0, 16'h0, 2'b10, 16'hA511, "rot3");

    for (int i = 0; i < 4; i++)
      step(2'b11, 2'b01, 2'b00, 8'h20, 8'h21, 16'h0, 16'h0, 2'b01, 16'hA520, "burst0");
    step(2'b11, 2'b01, 2'b00, 8'h20, 8'h21, 16'h0, 16'h0, 2'b10, 16'hA521, "burst_p1");
    step(2'b11, 2'b01, 2'b00, 8'h20, 8'h21, 16'h0, 16'h0, 2'b01, 16'hA520, "relock");
    step(2'b11, 2'b01, 2'b00, 8'h20, 8'h21, 16'h0, 16'h0, 2'b01, 16'hA520, "lock2");
    chk("locked_state", 32'(state_o), 32'd1);
    step(2'b11, 2'b00, 2'b00, 8'h20, 8'h21, 16'h0, 16'h0, 2'b10, 16'hA521, "unlock");
    step(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 16'h0, 16'h0, 2'b00, 16'h0000, "idle");
    chk("unlock_state", 32'(state_o), 32'd0);
    chk("unlock_owner", 32'(owner_o), 32'd1);

    // Leave ptr at 1, then reset in the middle of a port-1 read.
    step(2'b01, 2'b00, 2'b00, 8'h30, 8'h00, 16'h0, 16'h0, 2'b01, 16'hA530, "preptr");
    @(negedge Clk);
    req = 2'b10; lock = 2'b00; wr = 2'b00; addr = {8'h2A, 8'h00};
    #1;
    chk("rst_mid_gnt_pre", 32'(gnt), 32'b10);
    #1;
    Reset = 1'b0;
    #1;
    chk("rst_mid_gnt", 32'(gnt), 32'd0);
    chk("rst_mid_memwr", 32'(mem_wr), 32'd0);
    @(negedge Clk);
    chk("rst_mid_rvalid", 32'(rvalid), 32'd0);
    chk("rst_mid_state", 32'(state_o), 32'd0);
    req = 2'b00;
    Reset = 1'b1;
    step(2'b11, 2'b00, 2'b00, 8'h30, 8'h31, 16'h0, 16'h0, 2'b01, 16'hA530, "post_rst_ptr");
    step(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 16'h0, 16'h0, 2'b00, 16'h0000, "tail0");
    step(2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 16'h0, 16'h0, 2'b00, 16'h0000, "tail1");
    @(negedge Clk);
    #1;
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
